// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch monitor and its synchronizer.
package glitch_pkg;

    localparam int SYNC_STAGES   = 2;
    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        FINISH
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus rise/fall detection
// on the synchronized signal.
module sync_edge
    import glitch_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              edge_q;

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            edge_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~edge_q;
    assign fall  = ~sync_q[STAGES-1] & edge_q;

endmodule

// File: rtl/glitch_monitor.sv
// Fires a trigger pulse at the glitch generator and measures the delay to the
// glitch rising edge and the glitch high time, in clk cycles.
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int               CNT_W             = CNT_W_DEFAULT,
    parameter int               TRIG_PULSE_CYCLES = 4,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES    = CNT_W'(32'd24_000_000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             glitch_in,
    output logic             trigger,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] delay_cycles,
    output logic [CNT_W-1:0] width_cycles
);

    localparam int                TCNT_W    = (TRIG_PULSE_CYCLES > 1) ? $clog2(TRIG_PULSE_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TRIG_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state, state_nxt;
    logic              glitch_lvl, glitch_rise, glitch_fall;
    logic [TCNT_W-1:0] tcnt;
    logic [CNT_W-1:0]  dcnt, wcnt;
    logic              trig_last, rise_expired, width_expired;
    logic              meas_start, count_delay, rise_accept, rise_timeout;
    logic              count_width, width_capture, width_timeout;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (glitch_in),
        .level (glitch_lvl),
        .rise  (glitch_rise),
        .fall  (glitch_fall)
    );

    assign trig_last     = trigger && (tcnt == TCNT_LAST);
    assign rise_expired  = dcnt >= TIMEOUT_CYCLES;
    assign width_expired = wcnt >= TIMEOUT_CYCLES;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A rise during the trigger pulse is accepted; the pulse itself runs on
    // its own counter and completes regardless of the state.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = TRIG;
            TRIG:      if (glitch_rise) state_nxt = MEASURE;
                       else if (trig_last) state_nxt = WAIT_RISE;
            WAIT_RISE: if (glitch_rise) state_nxt = MEASURE;
                       else if (rise_expired) state_nxt = FINISH;
            MEASURE:   if (glitch_fall || width_expired) state_nxt = FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == TRIG) || (state == WAIT_RISE) || (state == MEASURE);
        done          = (state == FINISH);
        meas_start    = (state == IDLE) && start;
        count_delay   = (state == TRIG) || (state == WAIT_RISE);
        rise_accept   = count_delay && glitch_rise;
        rise_timeout  = (state == WAIT_RISE) && !glitch_rise && rise_expired;
        count_width   = (state == MEASURE) && glitch_lvl;
        width_capture = (state == MEASURE) && (glitch_fall || width_expired);
        width_timeout = (state == MEASURE) && !glitch_fall && width_expired;
    end

    // NOTE: non-blocking assignments keep every register update on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trigger      <= 1'b0;
            tcnt         <= '0;
            dcnt         <= '0;
            wcnt         <= '0;
            timeout      <= 1'b0;
            delay_cycles <= '0;
            width_cycles <= '0;
        end else if (meas_start) begin
            trigger      <= 1'b1;
            tcnt         <= '0;
            dcnt         <= '0;
            wcnt         <= '0;
            timeout      <= 1'b0;
            delay_cycles <= '0;
            width_cycles <= '0;
        end else begin
            if (trigger) begin
                if (trig_last) trigger <= 1'b0;
                else           tcnt    <= tcnt + TCNT_W'(1);
            end
            if (count_delay && dcnt != CNT_MAX) dcnt <= dcnt + CNT_W'(1);
            if (count_width && wcnt != CNT_MAX) wcnt <= wcnt + CNT_W'(1);
            if (rise_accept) begin
                delay_cycles <= dcnt;
                wcnt         <= CNT_W'(1);
            end
            if (rise_timeout) begin
                timeout      <= 1'b1;
                delay_cycles <= '0;
                width_cycles <= '0;
            end
            if (width_capture) width_cycles <= wcnt;
            if (width_timeout) timeout      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glitch_monitor.sv
// Scoreboard bench: one monitor with a long timeout for loopback/model tests,
// one with a 50-cycle timeout for the timeout cases.
module tb_glitch_monitor;

    typedef struct {
        logic [31:0] delay;
        logic [31:0] width;
        logic        to;
    } exp_t;

    logic        clk, rst_n;
    logic        start_m, gl_m, loop_m, glitch_m;
    logic        trig_m, busy_m, done_m, to_m;
    logic [31:0] delay_m, width_m;
    logic        start_t, gl_t;
    logic        trig_t, busy_t, done_t, to_t;
    logic [31:0] delay_t, width_t;

    exp_t q_m[$];
    exp_t q_t[$];
    exp_t e_m, e_t;
    int   errors = 0;
    int   checks = 0;
    int   trig_run = 0;
    int   trig_len = 0;
    int   trig_rises = 0;
    logic trig_q = 1'b0;

    assign glitch_m = loop_m ? trig_m : gl_m;

    glitch_monitor #(.CNT_W(32), .TRIG_PULSE_CYCLES(4), .TIMEOUT_CYCLES(32'd1000)) u_dut_main (
        .clk(clk), .rst_n(rst_n), .start(start_m), .glitch_in(glitch_m),
        .trigger(trig_m), .busy(busy_m), .done(done_m), .timeout(to_m),
        .delay_cycles(delay_m), .width_cycles(width_m)
    );

    glitch_monitor #(.CNT_W(32), .TRIG_PULSE_CYCLES(4), .TIMEOUT_CYCLES(32'd50)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .start(start_t), .glitch_in(gl_t),
        .trigger(trig_t), .busy(busy_t), .done(done_t), .timeout(to_t),
        .delay_cycles(delay_t), .width_cycles(width_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard monitors: compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done_m) begin
            if (q_m.size() == 0) check("main.unexpected_done", 1, 0);
            else begin
                e_m = q_m.pop_front();
                check("main.delay", delay_m, e_m.delay);
                check("main.width", width_m, e_m.width);
                check("main.timeout", to_m, e_m.to);
                check("main.busy_at_done", busy_m, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_t) begin
            if (q_t.size() == 0) check("to.unexpected_done", 1, 0);
            else begin
                e_t = q_t.pop_front();
                check("to.delay", delay_t, e_t.delay);
                check("to.width", width_t, e_t.width);
                check("to.timeout", to_t, e_t.to);
                check("to.busy_at_done", busy_t, 0);
            end
        end
    end

    // Trigger pulse length and pulse count on the main instance.
    always @(negedge clk) begin
        if (trig_m && !trig_q) trig_rises++;
        trig_q = trig_m;
        if (!rst_n) trig_run = 0;
        else if (trig_m) trig_run++;
        else if (trig_run != 0) begin
            trig_len = trig_run;
            trig_run = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 30000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start(input bit sel);
        @(posedge clk);
        #1;
        if (sel) start_t = 1'b1; else start_m = 1'b1;
        @(posedge clk);
        #1;
        if (sel) start_t = 1'b0; else start_m = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sel ? done_t : done_m) begin
                n = i;
                break;
            end
        end
    endtask

    // Generator model: glitch rises 'dly' cycles after the trigger rise.
    task automatic gen_glitch(input int dly, input int wid);
        repeat (dly) @(posedge clk);
        #1 gl_m = 1'b1;
        repeat (wid) @(posedge clk);
        #1 gl_m = 1'b0;
    endtask

    int n;
    int r0;

    initial begin
        rst_n = 1'b0; start_m = 1'b0; start_t = 1'b0;
        gl_m = 1'b0; gl_t = 1'b0; loop_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.main_flags", {trig_m, busy_m, done_m, to_m}, 0);
        check("rst.main_counts", {delay_m, width_m}, 0);
        check("rst.to_flags", {trig_t, busy_t, done_t, to_t}, 0);
        check("rst.to_counts", {delay_t, width_t}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Loopback: trigger fed straight back as the glitch.
        loop_m = 1'b1;
        r0 = trig_rises;
        q_m.push_back('{32'd2, 32'd4, 1'b0});
        pulse_start(0);
        wait_done(0, 50, n);
        check("loop.latency", n, 8);
        @(negedge clk);
        check("loop.done_one_cycle", {done_m, busy_m}, 0);
        check("loop.trig_len", trig_len, 4);
        check("loop.trig_count", trig_rises - r0, 1);
        loop_m = 1'b0;
        repeat (3) @(posedge clk);

        // Modelled generator: delay 100, width 12.
        r0 = trig_rises;
        q_m.push_back('{32'd102, 32'd12, 1'b0});
        pulse_start(0);
        gen_glitch(100, 12);
        wait_done(0, 50, n);
        check("model.done_seen", n > 0, 1);
        @(negedge clk);
        check("model.busy_after", busy_m, 0);
        check("model.trig_count", trig_rises - r0, 1);
        repeat (3) @(posedge clk);

        // Second start mid-measurement must be ignored.
        r0 = trig_rises;
        q_m.push_back('{32'd22, 32'd6, 1'b0});
        pulse_start(0);
        fork
            gen_glitch(20, 6);
            begin
                repeat (10) @(posedge clk);
                #1 start_m = 1'b1;
                @(posedge clk);
                #1 start_m = 1'b0;
            end
        join
        wait_done(0, 50, n);
        check("busy.done_seen", n > 0, 1);
        repeat (10) @(negedge clk);
        check("busy.trig_count", trig_rises - r0, 1);
        check("busy.trig_len", trig_len, 4);

        // Reset in the middle of MEASURE, then a clean measurement.
        pulse_start(0);
        fork
            gen_glitch(10, 30);
            begin
                repeat (20) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("midrst.flags", {trig_m, busy_m, done_m, to_m}, 0);
                check("midrst.counts", {delay_m, width_m}, 0);
            end
        join
        repeat (10) @(posedge clk);
        q_m.push_back('{32'd7, 32'd7, 1'b0});
        pulse_start(0);
        gen_glitch(5, 7);
        wait_done(0, 50, n);
        check("midrst.remeasure_done", n > 0, 1);

        // No glitch at all: timeout while waiting for the rise.
        q_t.push_back('{32'd0, 32'd0, 1'b1});
        pulse_start(1);
        wait_done(1, 100, n);
        check("noglitch.latency", n, 52);
        repeat (3) @(posedge clk);

        // Glitch rises and never falls: width timeout.
        q_t.push_back('{32'd12, 32'd50, 1'b1});
        pulse_start(1);
        repeat (10) @(posedge clk);
        #1 gl_t = 1'b1;
        wait_done(1, 100, n);
        check("stuck.done_seen", n > 0, 1);
        gl_t = 1'b0;
        repeat (5) @(negedge clk);
        check("hold.timeout", to_t, 1);
        check("hold.delay", delay_t, 12);
        check("hold.width", width_t, 50);

        repeat (5) @(negedge clk);
        check("main.queue_empty", q_m.size(), 0);
        check("to.queue_empty", q_t.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glitch_monitor.md
Name: glitch_monitor

Overview:
- Bench-side companion to the glitch generator: drives the generator's trigger input and captures its glitch output.
- Measures delay (trigger rise to glitch rise) and glitch width in clk cycles.
- Used for on-board self-calibration and loopback checks of the DELAY_TIME and GLITCH_TIME settings.
- Sits in the same 12 MHz clk domain. glitch_in is treated as asynchronous.

Parameters:
- CNT_W, 32, width of the delay, width and timeout counters.
- TRIG_PULSE_CYCLES, 4, trigger high time in clk cycles; must be >= 1.
- TIMEOUT_CYCLES, 32'd24_000_000, maximum cycles to wait for each glitch edge (2 s at 12 MHz).

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle request to run one measurement
- glitch_in  in  1  glitch output of the device under test; asynchronous
- trigger  out  1  registered trigger pulse to the generator
- busy  out  1  high while a measurement is in progress
- done  out  1  one-cycle pulse when a measurement completes
- timeout  out  1  sticky flag: last measurement timed out
- delay_cycles  out  CNT_W  measured trigger-to-glitch-rise delay
- width_cycles  out  CNT_W  measured glitch high time

Behaviour:
- Reset: synchronous, active-low. Applies on any clk edge with rst_n=0, including mid-measurement. All outputs go to 0, the FSM goes to IDLE, and the synchronizer flops clear to 0.
- Synchronizer: glitch_in passes through 2 flops (s1, s2), then s3 for edge detect.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, FINISH.
- IDLE:
  - start=1 moves to TRIG.
  - Next cycle: trigger=1, busy=1, dcnt=0, timeout cleared, delay_cycles/width_cycles cleared.
- TRIG:
  - Holds trigger=1 for exactly TRIG_PULSE_CYCLES cycles, then drops it. dcnt increments every cycle.
  - A rise seen during TRIG is accepted: go to MEASURE. trigger still completes its full pulse.
- WAIT_RISE:
  - dcnt increments each cycle.
  - On rise: delay_cycles <= dcnt, wcnt <= 1, go to MEASURE.
  - If dcnt reaches TIMEOUT_CYCLES first: timeout=1, delay_cycles=0, width_cycles=0, go to FINISH.
  - glitch_in already high at trigger time does not count; a 0->1 edge is required.
- MEASURE:
  - wcnt increments each cycle while s2=1.
  - On fall: width_cycles <= wcnt, go to FINISH.
  - If wcnt reaches TIMEOUT_CYCLES: width_cycles <= wcnt, timeout=1, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Result hold: delay_cycles, width_cycles and timeout hold until the next accepted start.
- Latency: for a cycle-aligned input, delay_cycles = true delay + 2; the 2 cycles are fixed synchronizer latency. width_cycles equals the true high time exactly.
- Counters saturate at 2^CNT_W-1 and never wrap. TIMEOUT_CYCLES < 2^CNT_W is required.
- start while busy=1 is ignored, including start in the FINISH cycle.
- rise and fall of a glitch shorter than one cycle may be missed. A missed glitch results in a timeout, not a false measurement.

Decomposition:
- Package glitch_pkg holds:
  - FSM state enum: IDLE, TRIG, WAIT_RISE, MEASURE, FINISH.
  - Constant SYNC_STAGES=2.
  - Default CNT_W.
- One natural sub-module: sync_edge (2-flop synchronizer plus rise/fall detect, synchronous active-low reset). It is reusable for the generator's trigger input.

Test Plan:
- Loopback: trigger wired to glitch_in, TRIG_PULSE_CYCLES=4, start pulse -> trigger high 4 cycles; done after measurement; delay_cycles=2, width_cycles=4, timeout=0.
- Modelled generator: glitch_in rises 100 cycles after trigger rise and stays high 12 cycles -> delay_cycles=102, width_cycles=12, one done pulse, busy low after done.
- No glitch, TIMEOUT_CYCLES=50: glitch_in held 0 -> done at dcnt=50; timeout=1, delay_cycles=0, width_cycles=0.
- Stuck high, TIMEOUT_CYCLES=50: glitch rises at delay 10 and never falls -> timeout=1, delay_cycles=12, width_cycles=50.
- Start while busy: second start pulse mid-measurement -> ignored; exactly one trigger pulse and one done.
- Reset mid-MEASURE: rst_n=0 for 1 cycle -> next edge gives all outputs 0 and FSM in IDLE. A new start then measures correctly from scratch.
